// File: rtl/cyber_pkg.sv
// cyber_pkg: shared FSM state encoding and LFSR width/tap constants for the computer press controller
package cyber_pkg;
  localparam int LFSR_W = 10;
  localparam int TAP_HI = 9;
  localparam int TAP_LO = 6;
  typedef enum logic [1:0] {IDLE, ARMED, PRESS, COOLDOWN} state_t;
endpackage

// File: rtl/cyber_lfsr.sv
// cyber_lfsr: 10-bit XNOR LFSR stepping on adv; ports clk, reset (async high), adv, q
module cyber_lfsr
  import cyber_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else if (adv) q <= {q[LFSR_W-2:0], ~(q[TAP_HI] ^ q[TAP_LO])};
endmodule

// File: rtl/cyber_press_ctrl.sv
// cyber_press_ctrl: computer-player press FSM; ports clk, reset, enable, tick, level, round_clr -> press, cooling, press_count
module cyber_press_ctrl
  import cyber_pkg::*;
#(
  parameter int unsigned COOLDOWN_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick,
  input  logic [8:0] level,
  input  logic       round_clr,
  output logic       press,
  output logic       cooling,
  output logic [7:0] press_count
);
  localparam logic [3:0] CD = 4'(COOLDOWN_TICKS);
  state_t state, next;
  logic [3:0] cnt, cnt_nxt;
  logic [LFSR_W-1:0] lfsr_q;
  logic hit;
  cyber_lfsr u_lfsr (.clk(clk), .reset(reset), .adv(tick & enable), .q(lfsr_q));
  // decision uses the pre-advance LFSR value; level=0 can never exceed it
  assign hit = {1'b0, level} > lfsr_q;
  always_comb begin
    next = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        next = enable ? ARMED : IDLE;
      end
      ARMED: next = !enable ? IDLE : (tick && hit) ? PRESS : ARMED;
      // the PRESS cycle always completes; ticks here do not count toward cooldown
      PRESS: begin
        cnt_nxt = CD;
        next = !enable ? IDLE : (CD == '0) ? ARMED : COOLDOWN;
      end
      COOLDOWN: begin
        cnt_nxt = (enable && tick) ? cnt - 4'd1 : cnt;
        next = !enable ? IDLE : (tick && cnt <= 4'd1) ? ARMED : COOLDOWN;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= cnt_nxt;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) press_count <= '0;
    else if (round_clr) press_count <= '0;
    else if (state == PRESS && press_count != 8'hFF) press_count <= press_count + 8'd1;
  assign press = state == PRESS;
  assign cooling = state == COOLDOWN;
endmodule
